tvf_recirc_buffer: RTL and testbench
====================================

// Module: tvf_recirc_buffer
// PURPOSE
//  Circular store for the query stream (t) and its boundary scores (v, f), placed between the data
//  processor and the PE array. Pass 1: the data processor loads t symbols, stored with v=f=0. Each
//  pass replays the entries into the array's t/v/f inputs. Last-PE t/v/f outputs are written back
//  as input for the next pass. Handles query lengths longer than the PE array.
// PARAMETERS
//  V_E_F_BIT  16    score width (v, f)
//  DEPTH      1024  entries; power of two, >= longest t sequence
//  ADDR_W     10    log2(DEPTH)
// PORTS
//  clk            in   1          single clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  i_flush        in   1          sync clear of pointers/counts/flags; FSM -> IDLE
//  i_load_valid   in   1          load beat from data processor
//  i_load_t       in   2          t symbol to load
//  i_load_last    in   1          final load beat; fixes sequence length
//  o_load_ready   out  1          load beat accepted this cycle
//  i_start        in   1          begin one replay pass (sampled in IDLE only)
//  i_update_t_w   in   1          array requests next entry (pop)
//  o_t            out  2          replayed t
//  o_v            out  V_E_F_BIT  replayed v
//  o_f            out  V_E_F_BIT  replayed f
//  o_t_valid      out  1          o_t/o_v/o_f valid this cycle
//  o_t_last       out  1          with o_t_valid: final entry of the pass
//  i_wb_valid     in   1          write-back beat from the last PE
//  i_wb_t         in   2          written-back t
//  i_wb_v         in   V_E_F_BIT  written-back v
//  i_wb_f         in   V_E_F_BIT  written-back f
//  o_busy         out  1          state != IDLE
//  o_pass_done    out  1          1-cycle pulse when a pass has fully written back
//  o_len          out  ADDR_W+1   stored sequence length
//  o_overflow     out  1          sticky: push dropped because buffer full
//  o_underflow    out  1          sticky: pop requested while empty or outside STREAM
// BEHAVIOUR
//  - Reset (rst=1 at clk edge):
//    - All outputs 0; rd_ptr = wr_ptr = count = len = 0; state = IDLE.
//    - Memory contents are don't-care.
//  - Entry format: {t[1:0], v, f}, width 2+2*V_E_F_BIT.
//  - Full: count == DEPTH. Empty: count == 0. Pointers wrap modulo DEPTH.
//  - FSM states: IDLE, LOAD, STREAM, DRAIN.
//    - IDLE -> LOAD on i_load_valid when len == 0.
//    - IDLE -> STREAM on i_start when len != 0; ignored when len == 0.
//    - LOAD -> IDLE on the accepted beat with i_load_last; len := count+1.
//    - STREAM -> DRAIN after the len-th pop.
//    - DRAIN -> IDLE when wb_cnt == len; o_pass_done pulses that cycle. Also fires from STREAM if
//      all write-backs have already arrived.
//  - LOAD:
//    - o_load_ready = (state == LOAD) && !full, combinational.
//    - Accepted beat pushes {i_load_t, 0, 0}.
//  - STREAM pop:
//    - i_update_t_w at cycle N with !empty: entry from rd_ptr on o_* at N+1, o_t_valid = 1 for
//      exactly one cycle. Output is registered (sync-read RAM), latency 1.
//    - Pops accepted on back-to-back cycles.
//    - o_t_last = 1 on the beat for pop index len-1 (pop_cnt counter).
//    - Outside STREAM, or when empty: no pop, o_t_valid = 0, set o_underflow.
//  - Write-back:
//    - Accepted in STREAM or DRAIN only; pushes {i_wb_t, i_wb_v, i_wb_f}; wb_cnt += 1.
//    - When full: beat dropped, o_overflow set, wb_cnt still increments so the pass terminates.
//    - i_wb_valid in IDLE/LOAD: dropped, o_overflow set.
//  - Simultaneous pop and push: count unchanged; both pointers advance.
//  - Read/write same address in one cycle: read returns the old data. Not reachable when
//    len <= DEPTH.
//  - i_flush or rst mid-pass: pass aborted, no o_pass_done, len := 0. Sticky flags clear only on
//    rst/i_flush.
//  - i_start outside IDLE ignored.
//  - Scores are stored and replayed verbatim; no arithmetic on v/f.
// STRUCTURE
//  - Shared package sw_pkg: V_E_F_BIT, DEPTH/ADDR_W, tvf_entry_t {t, v, f}, 2-bit base encoding.
//  - One sub-module: sw_ram_1r1w (DEPTH x entry width, sync write, registered sync read,
//    old-data on collision).
//  - Top holds FSM, pointers, count, len, pop_cnt, wb_cnt, flags.
// TESTING
//  1. Load t = 0,1,2,3 (last on 4th) -> o_len = 4; o_load_ready low after; o_busy high only during LOAD.
//  2. i_start, pop 4 cycles back-to-back -> o_t 0,1,2,3 with v=f=0 at N+1..N+4; o_t_last on 4th only.
//  3. Write back v = 5,6,7,8 with pops overlapping -> o_pass_done once after 4th wb. Second pass
//     replays v = 5,6,7,8 in order.
//  4. DEPTH = 4: load 4, then an extra wb in IDLE -> o_overflow = 1, count stays 4, data intact.
//  5. Pop with no pending entry in IDLE -> o_underflow = 1, o_t_valid stays 0.
//  6. rst/i_flush at the 2nd pop of a pass -> all outputs 0, len 0, no o_pass_done; fresh load works.

Source files
------------

// File: rtl/tvf_recirc_buffer_pkg.sv
// Shared types and default sizes for the t/v/f recirculation buffer between
// the data processor and the PE array.
package tvf_recirc_buffer_pkg;

  localparam int TVF_V_E_F_BIT = 16;
  localparam int TVF_DEPTH     = 1024;
  localparam int TVF_ADDR_W    = 10;

  // 2-bit nucleotide encoding carried on every t lane.
  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } tvf_base_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } tvf_state_e;

  typedef struct packed {
    logic [1:0]               t;
    logic [TVF_V_E_F_BIT-1:0] v;
    logic [TVF_V_E_F_BIT-1:0] f;
  } tvf_entry_t;

  function automatic tvf_entry_t make_entry(input logic [1:0] t,
                                            input logic [TVF_V_E_F_BIT-1:0] v,
                                            input logic [TVF_V_E_F_BIT-1:0] f);
    tvf_entry_t e;
    e.t = t;
    e.v = v;
    e.f = f;
    return e;
  endfunction

endpackage

// File: rtl/tvf_recirc_buffer_if.sv
// Bundle of load, replay and write-back signals for the recirculation buffer.
// Load uses valid/ready: a beat transfers on a clock edge where load_valid and
// load_ready are both high; the source holds t/last stable until then. Replay
// pops and write-back beats are single-cycle requests with no back-pressure.
interface tvf_recirc_buffer_if
  import tvf_recirc_buffer_pkg::*;
#(
  parameter int V_E_F_BIT = TVF_V_E_F_BIT,
  parameter int ADDR_W    = TVF_ADDR_W
) ();

  logic                 flush;
  logic                 load_valid;
  logic [1:0]           load_t;
  logic                 load_last;
  logic                 load_ready;
  logic                 start;
  logic                 update_t_w;
  logic [1:0]           t;
  logic [V_E_F_BIT-1:0] v;
  logic [V_E_F_BIT-1:0] f;
  logic                 t_valid;
  logic                 t_last;
  logic                 wb_valid;
  logic [1:0]           wb_t;
  logic [V_E_F_BIT-1:0] wb_v;
  logic [V_E_F_BIT-1:0] wb_f;
  logic                 busy;
  logic                 pass_done;
  logic [ADDR_W:0]      len;
  logic                 overflow;
  logic                 underflow;
  tvf_state_e           dbg_state;

  modport master (
    output flush, load_valid, load_t, load_last, start, update_t_w,
           wb_valid, wb_t, wb_v, wb_f,
    input  load_ready, t, v, f, t_valid, t_last, busy, pass_done, len,
           overflow, underflow, dbg_state
  );

  modport slave (
    input  flush, load_valid, load_t, load_last, start, update_t_w,
           wb_valid, wb_t, wb_v, wb_f,
    output load_ready, t, v, f, t_valid, t_last, busy, pass_done, len,
           overflow, underflow, dbg_state
  );

endinterface

// File: rtl/tvf_recirc_buffer_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read that
// returns the previous contents when both ports hit the same address.
module tvf_recirc_buffer_ram #(
  parameter int W      = 34,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the read register is cleared; the array itself holds don't-care data.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tvf_recirc_buffer.sv
// Circular t/v/f store: loaded once with query symbols, replayed into the PE
// array every pass, refilled by the last PE's write-back for the next pass.
module tvf_recirc_buffer
  import tvf_recirc_buffer_pkg::*;
#(
  parameter int V_E_F_BIT = TVF_V_E_F_BIT,
  parameter int DEPTH     = TVF_DEPTH,
  parameter int ADDR_W    = TVF_ADDR_W
) (
  input logic                clk,
  input logic                rst,
  tvf_recirc_buffer_if.slave bus
);

  localparam int EW = 2 + 2 * V_E_F_BIT;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  tvf_state_e        state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]     count, len, pop_cnt, wb_cnt;
  logic              overflow, underflow, t_valid, t_last, pass_done;

  logic              full, empty, load_ready, load_fire;
  logic              wb_window, wb_take, wb_fire, pop_fire, last_pop;
  logic              push, pass_end, clr;
  logic [EW-1:0]     wr_data, rd_data;

  assign clr        = rst || bus.flush;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign load_ready = (state == ST_LOAD) && !full;
  assign load_fire  = bus.load_valid && load_ready;
  assign wb_window  = (state == ST_STREAM) || (state == ST_DRAIN);
  // A beat inside the pass window counts toward termination even if dropped.
  assign wb_take    = bus.wb_valid && wb_window;
  assign wb_fire    = wb_take && !full;
  assign pop_fire   = bus.update_t_w && (state == ST_STREAM) && !empty;
  assign last_pop   = pop_fire && (pop_cnt == len - CW'(1));
  assign push       = load_fire || wb_fire;
  assign wr_data    = load_fire ? {bus.load_t, {(2*V_E_F_BIT){1'b0}}}
                                : {bus.wb_t, bus.wb_v, bus.wb_f};

  always_comb begin
    state_nxt = state;
    pass_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load_valid && (len == '0)) begin
          state_nxt = ST_LOAD;
        end else if (bus.start && (len != '0)) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_LOAD: begin
        if (load_fire && bus.load_last) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_pop) begin
          if (wb_cnt >= len) begin
            state_nxt = ST_IDLE;
            pass_end  = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (wb_cnt >= len) begin
          state_nxt = ST_IDLE;
          pass_end  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      len       <= '0;
      pop_cnt   <= '0;
      wb_cnt    <= '0;
      t_valid   <= 1'b0;
      t_last    <= 1'b0;
      pass_done <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      t_valid   <= pop_fire;
      t_last    <= last_pop;
      pass_done <= pass_end;
      count     <= count + CW'(push) - CW'(pop_fire);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (load_fire && bus.load_last) begin
        len <= count + 1'b1;
      end
      if ((state == ST_IDLE) && (state_nxt == ST_STREAM)) begin
        pop_cnt <= '0;
        wb_cnt  <= '0;
      end else begin
        if (pop_fire) begin
          pop_cnt <= pop_cnt + 1'b1;
        end
        if (wb_take) begin
          wb_cnt <= wb_cnt + 1'b1;
        end
      end
      if (bus.wb_valid && !wb_fire) begin
        overflow <= 1'b1;
      end
      if (bus.update_t_w && !pop_fire) begin
        underflow <= 1'b1;
      end
    end
  end

  tvf_recirc_buffer_ram #(
    .W      (EW),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop_fire),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.load_ready = load_ready;
  assign bus.t          = rd_data[EW-1 -: 2];
  assign bus.v          = rd_data[2*V_E_F_BIT-1 -: V_E_F_BIT];
  assign bus.f          = rd_data[V_E_F_BIT-1:0];
  assign bus.t_valid    = t_valid;
  assign bus.t_last     = t_last;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.pass_done  = pass_done;
  assign bus.len        = len;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_tvf_recirc_buffer.sv
// Bench for tvf_recirc_buffer (DEPTH = 4): table-driven passes, corner-case
// sequences and randomized passes checked against a FIFO reference model.
module tb_tvf_recirc_buffer;
  import tvf_recirc_buffer_pkg::*;

  localparam int VB = 16;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int EW = 2 + 2 * VB;

  typedef struct packed {
    logic [2:0]          n;
    logic [3:0][1:0]     t;
    logic [3:0][VB-1:0]  wv;
    logic [3:0][VB-1:0]  wf;
    logic [2:0]          exp_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: buffer contents in FIFO order plus sticky flags.
  logic [EW-1:0] exp_q[$];
  int            mdl_len;
  logic          mdl_ovf, mdl_unf;
  vec_t          tab [5];

  always #5 clk = ~clk;

  tvf_recirc_buffer_if #(.V_E_F_BIT(VB), .ADDR_W(AW)) bus ();

  tvf_recirc_buffer #(.V_E_F_BIT(VB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_t     = 2'd0;
    bus.load_last  = 1'b0;
    bus.start      = 1'b0;
    bus.update_t_w = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_t       = 2'd0;
    bus.wb_v       = '0;
    bus.wb_f       = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_t_valid"}, bus.t_valid, 0);
    chk({tag, "_t_last"}, bus.t_last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_pass_done"}, bus.pass_done, 0);
    chk({tag, "_len"}, bus.len, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_underflow"}, bus.underflow, 0);
    chk({tag, "_load_ready"}, bus.load_ready, 0);
    chk({tag, "_tvf"}, {bus.t, bus.v, bus.f}, 0);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_q.delete();
    mdl_len = 0;
    mdl_ovf = 1'b0;
    mdl_unf = 1'b0;
  endtask

  task automatic load_seq(input int n, input logic [3:0][1:0] ts);
    logic acc;
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_t     = ts[i];
      bus.load_last  = (i == n - 1);
      acc = 1'b0;
      for (int w = 0; w < 8; w++) begin
        acc = bus.load_ready;
        chk("busy_during_load", bus.busy, acc);
        tick();
        if (acc) break;
      end
      if (!acc) chk("load_timeout", 0, 1);
      exp_q.push_back({ts[i], {(2*VB){1'b0}}});
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    mdl_len = n;
    chk("len_after_load", bus.len, n);
    chk("load_ready_after", bus.load_ready, 0);
    chk("busy_after_load", bus.busy, 0);
  endtask

  task automatic run_pass(input bit b2b, input bit use_tab, input logic [3:0][1:0] tt,
                          input logic [3:0][VB-1:0] tv, input logic [3:0][VB-1:0] tf);
    int pops, wbs, outs, pulses;
    bit pop_now, wb_now, exp_last;
    logic [EW-1:0] exp_ent, wb_ent;
    pops = 0; wbs = 0; outs = 0; pulses = 0;
    exp_ent = '0; wb_ent = '0; exp_last = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_stream", bus.busy, 1);
    for (int cyc = 0; cyc < 400 && wbs < mdl_len; cyc++) begin
      pop_now = (pops < mdl_len) && (b2b || $urandom_range(0, 3) != 0);
      wb_now  = (wbs < outs) && ($urandom_range(0, 2) != 0);
      bus.update_t_w = pop_now;
      bus.wb_valid   = wb_now;
      bus.start      = ($urandom_range(0, 7) == 0);
      if (wb_now) begin
        if (use_tab) wb_ent = {tt[wbs], tv[wbs], tf[wbs]};
        else         wb_ent = {2'($urandom), 16'($urandom), 16'($urandom)};
        {bus.wb_t, bus.wb_v, bus.wb_f} = wb_ent;
      end
      if (pop_now) begin
        exp_ent  = exp_q.pop_front();
        exp_last = (pops == mdl_len - 1);
        pops++;
      end
      tick();
      chk("t_valid", bus.t_valid, pop_now);
      if (pop_now) begin
        chk("replay_tvf", {bus.t, bus.v, bus.f}, exp_ent);
        chk("t_last", bus.t_last, exp_last);
        outs++;
      end else begin
        chk("t_last_quiet", bus.t_last, 0);
      end
      if (wb_now) begin
        exp_q.push_back(wb_ent);
        wbs++;
      end
      if (bus.pass_done) pulses++;
    end
    idle_inputs();
    for (int w = 0; w < 6; w++) begin
      tick();
      if (bus.pass_done) pulses++;
      chk("t_valid_post", bus.t_valid, 0);
    end
    chk("pass_done_once", pulses, 1);
    chk("busy_end", bus.busy, 0);
    chk("len_kept", bus.len, mdl_len);
    chk("overflow_flag", bus.overflow, mdl_ovf);
    chk("underflow_flag", bus.underflow, mdl_unf);
  endtask

  // Flush or reset in the same cycle as the second pop of a pass.
  task automatic abort_mid_pass(input bit use_rst);
    logic [3:0][1:0] ts;
    ts = {2'd1, 2'd3, 2'd0, 2'd2};
    do_flush();
    load_seq(4, ts);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.update_t_w = 1'b1;
    tick();
    chk("abort_first_pop", {bus.t_valid, bus.t}, {1'b1, 2'd2});
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk_all_zero(use_rst ? "abort_rst" : "abort_flush");
    for (int w = 0; w < 5; w++) begin
      tick();
      chk("abort_no_done", bus.pass_done, 0);
    end
    exp_q.delete();
    mdl_len = 0; mdl_ovf = 1'b0; mdl_unf = 1'b0;
    ts = {2'd0, 2'd0, 2'd3, 2'd1};
    load_seq(2, ts);
    run_pass(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][1:0] rts;
    int rn;
    tab[0] = '{n: 3'd4, t: {BASE_T, BASE_G, BASE_C, BASE_A},
               wv: {16'd8, 16'd7, 16'd6, 16'd5}, wf: '0, exp_len: 3'd4};
    tab[1] = '{n: 3'd1, t: {2'd0, 2'd0, 2'd0, 2'd2},
               wv: {48'd0, 16'hFFFF}, wf: {48'd0, 16'h8000}, exp_len: 3'd1};
    tab[2] = '{n: 3'd3, t: {2'd0, 2'd1, 2'd0, 2'd3},
               wv: {16'd0, 16'h1234, 16'h0001, 16'hBEEF},
               wf: {16'd0, 16'h7FFF, 16'h0F0F, 16'h0002}, exp_len: 3'd3};
    tab[3] = '{n: 3'd2, t: {2'd0, 2'd0, 2'd2, 2'd1},
               wv: {32'd0, 16'hA5A5, 16'h5A5A}, wf: {32'd0, 16'h0000, 16'hFFFF}, exp_len: 3'd2};
    tab[4] = '{n: 3'd4, t: {2'd3, 2'd3, 2'd3, 2'd3},
               wv: {16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF},
               wf: {16'h0001, 16'h8000, 16'hFFFF, 16'h1111}, exp_len: 3'd4};

    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");
    chk("reset_state", bus.dbg_state, ST_IDLE);
    exp_q.delete();
    mdl_len = 0; mdl_ovf = 1'b0; mdl_unf = 1'b0;

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_ignored_empty", bus.busy, 0);

    for (int i = 0; i < 5; i++) begin
      do_flush();
      load_seq(int'(tab[i].n), tab[i].t);
      chk("tab_len", bus.len, tab[i].exp_len);
      run_pass(i == 0, 1'b1, tab[i].t, tab[i].wv, tab[i].wf);
      run_pass(i == 0, 1'b0, '0, '0, '0);
      run_pass(1'b0, 1'b0, '0, '0, '0);
    end

    // Full buffer plus a write-back while idle: dropped, flagged, data kept.
    do_flush();
    load_seq(4, {2'd3, 2'd2, 2'd1, 2'd0});
    chk("ovf_before", bus.overflow, 0);
    bus.wb_valid = 1'b1;
    {bus.wb_t, bus.wb_v, bus.wb_f} = {2'd3, 16'hDEAD, 16'hBEEF};
    tick();
    bus.wb_valid = 1'b0;
    mdl_ovf = 1'b1;
    chk("ovf_idle_wb", bus.overflow, 1);
    chk("ovf_len", bus.len, 4);
    run_pass(1'b1, 1'b0, '0, '0, '0);

    // Pop requested while idle.
    do_flush();
    chk("unf_cleared", bus.underflow, 0);
    bus.update_t_w = 1'b1;
    tick();
    bus.update_t_w = 1'b0;
    chk("unf_idle_valid", bus.t_valid, 0);
    chk("unf_idle_flag", bus.underflow, 1);
    tick();
    chk("unf_sticky", bus.underflow, 1);

    abort_mid_pass(1'b0);
    abort_mid_pass(1'b1);

    for (int it = 0; it < 16; it++) begin
      do_flush();
      rn = $urandom_range(1, DEPTH);
      rts = 8'($urandom);
      load_seq(rn, rts);
      run_pass(1'b0, 1'b0, '0, '0, '0);
      if ($urandom_range(0, 1) == 1) begin
        bus.wb_valid = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        mdl_ovf = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.update_t_w = 1'b1;
        tick();
        bus.update_t_w = 1'b0;
        mdl_unf = 1'b1;
        chk("rand_idle_pop_valid", bus.t_valid, 0);
      end
      run_pass($urandom_range(0, 1) == 1, 1'b0, '0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
